// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with a two-entry skid buffer, synchronous flush
// and a saturating back-pressure (stall) counter.
//
// Handshake: a bundle moves across an interface in any cycle where valid and
// ready are both high at the rising edge (push on the _m side, pop on the _w
// side). valid never depends combinationally on ready; ready_m is derived
// only from the registered occupancy, so there is no path from ready_w.
module mem_wb_skid_reg #(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int SRC_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             valid_m,
  output logic             ready_m,
  input  logic             reg_write_m,
  input  logic [SRC_W-1:0] result_src_m,
  input  logic [REG_W-1:0] rd_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  read_data_m,
  input  logic [XLEN-1:0]  pc_plus_4_m,
  output logic             valid_w,
  input  logic             ready_w,
  output logic             reg_write_w,
  output logic [SRC_W-1:0] result_src_w,
  output logic [REG_W-1:0] rd_w,
  output logic [XLEN-1:0]  alu_result_w,
  output logic [XLEN-1:0]  read_data_w,
  output logic [XLEN-1:0]  pc_plus_4_w,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic             reg_write;
    logic [SRC_W-1:0] result_src;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  read_data;
    logic [XLEN-1:0]  pc_plus_4;
  } payload_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t   state;
  state_t   next_state;
  payload_t head;
  payload_t skid;
  payload_t in_bundle;

  logic push;
  logic pop;
  logic load_head_in;
  logic load_skid_in;
  logic load_head_skid;

  assign in_bundle = '{
    reg_write:  reg_write_m,
    result_src: result_src_m,
    rd:         rd_m,
    alu_result: alu_result_m,
    read_data:  read_data_m,
    pc_plus_4:  pc_plus_4_m
  };

  assign ready_m   = (state != FULL);
  assign valid_w   = (state != EMPTY);
  assign push      = valid_m & ready_m;
  assign pop       = valid_w & ready_w;
  assign state_dbg = state;

  // Occupancy transitions and register load selects; flush discards everything.
  always_comb begin
    next_state     = state;
    load_head_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_head_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (push) begin
          load_head_in = 1'b1;
          next_state   = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_in = 1'b1;
        end else if (push) begin
          load_skid_in = 1'b1;
          next_state   = FULL;
        end else if (pop) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          load_head_skid = 1'b1;
          next_state     = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
    if (flush) begin
      next_state     = EMPTY;
      load_head_in   = 1'b0;
      load_skid_in   = 1'b0;
      load_head_skid = 1'b0;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Head and skid payload registers; contents hold while not loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (load_head_in) begin
        head <= in_bundle;
      end else if (load_head_skid) begin
        head <= skid;
      end
      if (load_skid_in) begin
        skid <= in_bundle;
      end
    end
  end

  // Saturating count of cycles where Writeback holds off a valid head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (valid_w && !ready_w && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // A bubble must never write the register file.
  assign reg_write_w  = head.reg_write & valid_w;
  assign result_src_w = head.result_src;
  assign rd_w         = head.rd;
  assign alu_result_w = head.alu_result;
  assign read_data_w  = head.read_data;
  assign pc_plus_4_w  = head.pc_plus_4;

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed bench for mem_wb_skid_reg: reset, streaming, back-pressure,
// flush, bubble gating and counter saturation (second instance, CNT_W=4).
module tb_mem_wb_skid_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        valid_m;
  logic        reg_write_m;
  logic [1:0]  result_src_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m;
  logic [31:0] read_data_m;
  logic [31:0] pc_plus_4_m;
  logic        ready_w;

  logic        ready_m;
  logic        valid_w;
  logic        reg_write_w;
  logic [1:0]  result_src_w;
  logic [4:0]  rd_w;
  logic [31:0] alu_result_w;
  logic [31:0] read_data_w;
  logic [31:0] pc_plus_4_w;
  logic [15:0] stall_cnt;
  logic [1:0]  state_dbg;

  logic        s_ready_m;
  logic        s_valid_w;
  logic        s_reg_write_w;
  logic [1:0]  s_result_src_w;
  logic [4:0]  s_rd_w;
  logic [31:0] s_alu_result_w;
  logic [31:0] s_read_data_w;
  logic [31:0] s_pc_plus_4_w;
  logic [3:0]  s_stall_cnt;
  logic [1:0]  s_state_dbg;

  int n_pass;
  int n_total;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_wb_skid_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .valid_m(valid_m), .ready_m(ready_m),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .rd_m(rd_m),
    .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus_4_m(pc_plus_4_m),
    .valid_w(valid_w), .ready_w(ready_w),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w), .rd_w(rd_w),
    .alu_result_w(alu_result_w), .read_data_w(read_data_w), .pc_plus_4_w(pc_plus_4_w),
    .stall_cnt(stall_cnt), .state_dbg(state_dbg)
  );

  mem_wb_skid_reg #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .valid_m(valid_m), .ready_m(s_ready_m),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .rd_m(rd_m),
    .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus_4_m(pc_plus_4_m),
    .valid_w(s_valid_w), .ready_w(ready_w),
    .reg_write_w(s_reg_write_w), .result_src_w(s_result_src_w), .rd_w(s_rd_w),
    .alu_result_w(s_alu_result_w), .read_data_w(s_read_data_w), .pc_plus_4_w(s_pc_plus_4_w),
    .stall_cnt(s_stall_cnt), .state_dbg(s_state_dbg)
  );

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [31:0] alu);
    valid_m      = v;
    reg_write_m  = rw;
    rd_m         = rd;
    alu_result_m = alu;
    result_src_m = rd[1:0];
    read_data_m  = alu + 32'h1000;
    pc_plus_4_m  = {27'd0, rd} << 2;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    ready_w = 1'b0;
    drive(1'b1, 1'b1, 5'd7, 32'hdead);

    // Reset with valid_m high
    step();
    step();
    chk("rst_valid_w", valid_w, 0);
    chk("rst_ready_m", ready_m, 1);
    chk("rst_reg_write_w", reg_write_w, 0);
    chk("rst_rd_w", rd_w, 0);
    chk("rst_alu_w", alu_result_w, 0);
    chk("rst_read_data_w", read_data_w, 0);
    chk("rst_pc_w", pc_plus_4_w, 0);
    chk("rst_src_w", result_src_w, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_state", state_dbg, 0);

    // Streaming with ready_w=1
    rst_n   = 1'b1;
    ready_w = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 32'h10 + 32'(i));
      step();
      chk("stream_valid_w", valid_w, 1);
      chk("stream_rd_w", rd_w, i + 1);
      chk("stream_alu_w", alu_result_w, 32'h10 + i);
      chk("stream_read_data_w", read_data_w, 32'h1010 + i);
      chk("stream_reg_write_w", reg_write_w, 1);
      chk("stream_ready_m", ready_m, 1);
    end

    // Drain: bubble gating of reg_write, payload holds
    drive(1'b0, 1'b1, 5'd0, 32'h0);
    step();
    chk("bubble_valid_w", valid_w, 0);
    chk("bubble_reg_write_w", reg_write_w, 0);
    chk("bubble_rd_hold", rd_w, 8);
    chk("bubble_stall_cnt", stall_cnt, 0);

    // Back-pressure
    ready_w = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 32'h33);
    step();
    chk("bp_one_rd_w", rd_w, 3);
    chk("bp_one_ready_m", ready_m, 1);
    chk("bp_one_cnt", stall_cnt, 0);
    drive(1'b1, 1'b1, 5'd4, 32'h44);
    step();
    chk("bp_full_state", state_dbg, 2);
    chk("bp_full_ready_m", ready_m, 0);
    chk("bp_full_cnt", stall_cnt, 1);
    drive(1'b1, 1'b1, 5'd5, 32'h55);
    step();
    step();
    chk("bp_cnt3", stall_cnt, 3);
    chk("bp_hold_rd_w", rd_w, 3);
    chk("bp_hold_state", state_dbg, 2);
    ready_w = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("bp_pop1_rd_w", rd_w, 4);
    chk("bp_pop1_alu_w", alu_result_w, 32'h44);
    chk("bp_pop1_ready_m", ready_m, 1);
    chk("bp_pop1_cnt", stall_cnt, 3);
    step();
    chk("bp_drain_valid_w", valid_w, 0);

    // Flush from FULL with a push attempt
    ready_w = 1'b0;
    drive(1'b1, 1'b1, 5'd10, 32'hA0);
    step();
    drive(1'b1, 1'b1, 5'd11, 32'hB0);
    step();
    chk("fl_pre_state", state_dbg, 2);
    chk("fl_pre_cnt", stall_cnt, 4);
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd9, 32'h99);
    step();
    chk("fl_valid_w", valid_w, 0);
    chk("fl_reg_write_w", reg_write_w, 0);
    chk("fl_ready_m", ready_m, 1);
    chk("fl_cnt", stall_cnt, 5);
    flush   = 1'b0;
    ready_w = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("fl_no_ghost", valid_w, 0);
    drive(1'b1, 1'b1, 5'd12, 32'hC0);
    step();
    chk("fl_after_valid_w", valid_w, 1);
    chk("fl_after_rd_w", rd_w, 12);
    chk("fl_after_cnt", stall_cnt, 5);

    // Saturation on the CNT_W=4 instance
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("sat_rst_cnt", s_stall_cnt, 0);
    chk("sat_rst_main_cnt", stall_cnt, 0);
    ready_w = 1'b0;
    drive(1'b1, 1'b1, 5'd13, 32'hD0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) chk("sat_cnt10", s_stall_cnt, 10);
      if (k == 15) chk("sat_cnt15", s_stall_cnt, 15);
    end
    chk("sat_cnt20", s_stall_cnt, 15);
    chk("sat_main_cnt20", stall_cnt, 20);
    chk("sat_rd_hold", s_rd_w, 13);
    chk("sat_valid_w", s_valid_w, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
